pipelined_alu: RTL and testbench
================================

PIPELINED_ALU -- requirements
Module: pipelined_alu

Interface
REQ-001 Parameter WIDTH, default 8, data path width in bits (legal range 4..32).
REQ-002 Parameter IMM_W, default $clog2(WIDTH), width of imm (bit index / shift count).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-005 InValid  input  1  operation request present.
REQ-006 InReady  output  1  block can accept an operation.
REQ-007 InputA  input  WIDTH  operand A.
REQ-008 InputB  input  WIDTH  operand B.
REQ-009 OP  input  4  opcode: 0000 ADD, 0001 LSH, 0010 XOR, 0011 AND, 0100 FLIP, 0101 CPY, 0110 GETB, 0111 BXOR, 1000 SETB, 1001 MUL, 1010 SHLN; 1011-1111 reserved.
REQ-010 SC_in  input  1  shift fill bit / SETB value.
REQ-011 imm  input  IMM_W  bit index or shift count.
REQ-012 Out  output  WIDTH  registered result.
REQ-013 OutValid  output  1  result valid.
REQ-014 OutReady  input  1  consumer takes result.
REQ-015 Zero, Parity, OutBit, Carry  output  1 each  registered flags.

Function
REQ-016 FSM states IDLE, EXEC, DONE; InReady SHALL be 1 only in IDLE.
REQ-017 Accept on InValid && InReady; InputA, InputB, OP, SC_in, imm SHALL be latched on that edge; later input changes SHALL have no effect.
REQ-018 Single-cycle ops (0000-1000, reserved, SHLN with imm=0): IDLE -> DONE, OutValid high on the first edge after accept (latency 1).
REQ-019 ADD: Out = (A+B) mod 2^WIDTH, Carry = bit WIDTH of the sum.
REQ-020 LSH: Out = {A[WIDTH-2:0], SC_in}, Carry = A[WIDTH-1].
REQ-021 XOR: Out = zero-extended ^A. AND: A&B. BXOR: A^B. CPY: A.
REQ-022 FLIP: Out = A with bit imm inverted. SETB: Out = A with bit imm = SC_in.
REQ-023 GETB: Out = A, OutBit = A[imm].
REQ-024 For FLIP/SETB/GETB with imm >= WIDTH: Out = A, OutBit = 0.
REQ-025 Reserved opcodes: Out = A, Carry = 0.
REQ-026 MUL: IDLE -> EXEC; shift-add, one multiplier bit per cycle for WIDTH cycles, then DONE; Out = low WIDTH bits of A*B, Carry = 1 if the upper WIDTH bits are nonzero; OutValid asserts WIDTH+1 edges after accept.
REQ-027 SHLN with imm=n>0: IDLE -> EXEC; one-bit left shift per cycle filling SC_in, n cycles, then DONE; Out = (A<<n) with the low n bits = SC_in, Carry = last bit shifted out; OutValid n+1 edges after accept; n >= WIDTH yields all SC_in.
REQ-028 Zero = (Out == 0); Parity = ^Out; OutBit = Out[0] for all ops except GETB; Carry = 0 where not specified.
REQ-029 In DONE, Out and all flags SHALL hold stable until OutValid && OutReady; on that edge go to IDLE, OutValid = 0, InReady = 1 on the following cycle (no same-cycle re-accept).
REQ-030 In EXEC, InValid and OutReady SHALL be ignored; Out and flags keep their previous values until DONE.
REQ-031 OutReady high in IDLE SHALL have no effect.

Reset
REQ-032 Reset low in any state (including mid-EXEC) SHALL abort the operation, go to IDLE, and drive Out = 0, OutValid = 0, Carry = 0, OutBit = 0, Parity = 0, Zero = 1; InReady = 1 once Reset is high.
REQ-033 The first acceptance after reset deassertion SHALL be possible on the first rising edge with Reset high.

Verification
REQ-034 WIDTH=8: ADD A=0xFF, B=0x01, OutReady=1 -> after 1 cycle Out=0x00, Zero=1, Carry=1, OutValid one cycle.
REQ-035 WIDTH=8: MUL A=13, B=11 -> InReady low 9 cycles, OutValid at edge 9, Out=0x8F, Carry=0; A=0x20, B=0x10 -> Out=0x00, Carry=1, Zero=1.
REQ-036 WIDTH=8: SHLN A=0xB4, imm=3, SC_in=1 -> OutValid at edge 4, Out=0xA7, Carry=1; imm=0 -> latency 1, Out=0xB4.
REQ-037 Back-pressure: GETB A=0x04, imm=2, OutReady=0 for 5 cycles -> Out=0x04, OutBit=1 held stable, InReady=0, new InValid ignored; OutReady=1 -> IDLE next cycle.
REQ-038 Reset pulse in EXEC cycle 4 of MUL -> immediate Out=0, OutValid=0, Zero=1; new ADD 1+1 after release -> Out=0x02.
REQ-039 WIDTH=16: FLIP A=0x0001, imm=15 -> Out=0x8001, Parity=0; SETB A=0x00B4, imm=1, SC_in=1 -> Out=0x00B6.

Source files
------------

// File: rtl/pipelined_alu.sv
// pipelined_alu: handshaked ALU with single-cycle logic/arith ops and
// iterative multi-cycle MUL (shift-add) and SHLN (n-bit shift with fill).
//
// Ports
//   Clk, Reset       clock, asynchronous active-low reset
//   InValid/InReady  request handshake; InReady is high only while idle
//   InputA, InputB   operands (WIDTH bits)
//   OP               4-bit opcode
//   SC_in            shift fill bit / SETB value
//   imm              bit index or shift count (IMM_W bits)
//   Out              registered result (WIDTH bits)
//   OutValid/OutReady result handshake; result held until taken
//   Zero, Parity, OutBit, Carry  registered result flags
module pipelined_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IMM_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic [3:0]       OP,
  input  logic             SC_in,
  input  logic [IMM_W-1:0] imm,
  output logic [WIDTH-1:0] Out,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             Zero,
  output logic             Parity,
  output logic             OutBit,
  output logic             Carry
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_LSH  = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_FLIP = 4'h4;
  localparam logic [3:0] OP_CPY  = 4'h5;
  localparam logic [3:0] OP_GETB = 4'h6;
  localparam logic [3:0] OP_BXOR = 4'h7;
  localparam logic [3:0] OP_SETB = 4'h8;
  localparam logic [3:0] OP_MUL  = 4'h9;
  localparam logic [3:0] OP_SHLN = 4'hA;

  // Counter must hold both WIDTH (MUL iterations) and the largest imm.
  localparam int unsigned CNT_LOG = $clog2(WIDTH + 1);
  localparam int unsigned CNT_W   = (IMM_W > CNT_LOG) ? IMM_W : CNT_LOG;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 is_mul_q, is_mul_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 sc_q, sc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 parity_q, parity_d;
  logic                 out_bit_q, out_bit_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;

  // Single-cycle datapath, evaluated on the live inputs at the accept edge.
  logic [WIDTH:0]       add_sum;
  logic [WIDTH-1:0]     bit_mask;
  logic [WIDTH-1:0]     sc_out;
  logic                 sc_carry;
  logic                 sc_is_getb;
  logic                 sc_bit;

  always_comb begin
    add_sum    = {1'b0, InputA} + {1'b0, InputB};
    // An out-of-range index shifts the 1 out entirely, so FLIP/SETB leave A
    // untouched and GETB reads 0 without a separate range check.
    bit_mask   = WIDTH'(1) << imm;
    sc_out     = InputA;
    sc_carry   = 1'b0;
    sc_is_getb = 1'b0;
    case (OP)
      OP_ADD: begin
        sc_out   = add_sum[WIDTH-1:0];
        sc_carry = add_sum[WIDTH];
      end
      OP_LSH: begin
        sc_out   = {InputA[WIDTH-2:0], SC_in};
        sc_carry = InputA[WIDTH-1];
      end
      OP_XOR:  sc_out = {{(WIDTH-1){1'b0}}, ^InputA};
      OP_AND:  sc_out = InputA & InputB;
      OP_FLIP: sc_out = InputA ^ bit_mask;
      OP_CPY:  sc_out = InputA;
      OP_GETB: sc_is_getb = 1'b1;
      OP_BXOR: sc_out = InputA ^ InputB;
      OP_SETB: sc_out = SC_in ? (InputA | bit_mask) : (InputA & ~bit_mask);
      default: sc_out = InputA;  // reserved codes and SHLN by zero
    endcase
    sc_bit = sc_is_getb ? (|(InputA & bit_mask)) : sc_out[0];
  end

  // One iteration of the multi-cycle ops.
  // MUL keeps {partial_hi, remaining multiplier} in prod_q and retires one
  // multiplier bit per cycle from the LSB end.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   prod_step;
  logic [WIDTH-1:0]     shl_step;
  logic [WIDTH-1:0]     ex_out;
  logic                 ex_carry;

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q & {WIDTH{prod_q[0]}}};
    prod_step = {mul_sum, prod_q[WIDTH-1:1]};
    shl_step  = {a_q[WIDTH-2:0], sc_q};
    ex_out    = is_mul_q ? prod_step[WIDTH-1:0] : shl_step;
    ex_carry  = is_mul_q ? (|prod_step[2*WIDTH-1:WIDTH]) : a_q[WIDTH-1];
  end

  // Next-state and result-load logic.
  logic                 load;
  logic [WIDTH-1:0]     res_out;
  logic                 res_carry;
  logic                 res_bit;

  always_comb begin
    state_d   = state_q;
    is_mul_d  = is_mul_q;
    a_d       = a_q;
    prod_d    = prod_q;
    sc_d      = sc_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    parity_d  = parity_q;
    out_bit_d = out_bit_q;
    load      = 1'b0;
    res_out   = sc_out;
    res_carry = sc_carry;
    res_bit   = sc_bit;

    case (state_q)
      S_IDLE: begin
        if (InValid && in_ready_q) begin
          if (OP == OP_MUL) begin
            is_mul_d = 1'b1;
            a_d      = InputA;
            prod_d   = {{WIDTH{1'b0}}, InputB};
            cnt_d    = CNT_W'(WIDTH);
            state_d  = S_EXEC;
          end else if ((OP == OP_SHLN) && (imm != '0)) begin
            is_mul_d = 1'b0;
            a_d      = InputA;
            sc_d     = SC_in;
            cnt_d    = CNT_W'(imm);
            state_d  = S_EXEC;
          end else begin
            load    = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_EXEC: begin
        a_d    = is_mul_q ? a_q : shl_step;
        prod_d = is_mul_q ? prod_step : prod_q;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          load      = 1'b1;
          res_out   = ex_out;
          res_carry = ex_carry;
          res_bit   = ex_out[0];
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (OutReady) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      out_d     = res_out;
      carry_d   = res_carry;
      out_bit_d = res_bit;
      zero_d    = (res_out == '0);
      parity_d  = ^res_out;
    end

    out_valid_d = (state_d == S_DONE);
    in_ready_d  = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      is_mul_q    <= 1'b0;
      a_q         <= '0;
      prod_q      <= '0;
      sc_q        <= 1'b0;
      cnt_q       <= '0;
      out_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b1;
      parity_q    <= 1'b0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      is_mul_q    <= is_mul_d;
      a_q         <= a_d;
      prod_q      <= prod_d;
      sc_q        <= sc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign Out      = out_q;
  assign OutValid = out_valid_q;
  assign InReady  = in_ready_q;
  assign Zero     = zero_q;
  assign Parity   = parity_q;
  assign OutBit   = out_bit_q;
  assign Carry    = carry_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Scoreboard bench for pipelined_alu: an 8-bit and a 16-bit instance share
// operand/opcode drivers; each has its own InValid and its own monitor.
module tb_pipelined_alu;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_LSH  = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_FLIP = 4'h4;
  localparam logic [3:0] OP_CPY  = 4'h5;
  localparam logic [3:0] OP_GETB = 4'h6;
  localparam logic [3:0] OP_BXOR = 4'h7;
  localparam logic [3:0] OP_SETB = 4'h8;
  localparam logic [3:0] OP_MUL  = 4'h9;
  localparam logic [3:0] OP_SHLN = 4'hA;
  localparam logic [3:0] OP_RSV  = 4'hB;

  logic        clk;
  logic        rst_n;
  logic        iv8, iv16;
  logic        out_ready;
  logic [15:0] a_drv, b_drv;
  logic [3:0]  op_drv;
  logic        sc_drv;
  logic [3:0]  imm_drv;

  logic        rdy8, ov8, z8, p8, ob8, c8;
  logic [7:0]  out8;
  logic        rdy16, ov16, z16, p16, ob16, c16;
  logic [15:0] out16;

  typedef struct {
    logic [15:0] out;
    logic        c;
    logic        z;
    logic        p;
    logic        b;
    string       name;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  int   n_tests;
  int   n_fail;

  pipelined_alu #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .Reset(rst_n), .InValid(iv8), .InReady(rdy8),
    .InputA(a_drv[7:0]), .InputB(b_drv[7:0]), .OP(op_drv), .SC_in(sc_drv),
    .imm(imm_drv[2:0]), .Out(out8), .OutValid(ov8), .OutReady(out_ready),
    .Zero(z8), .Parity(p8), .OutBit(ob8), .Carry(c8)
  );

  pipelined_alu #(.WIDTH(16)) u_dut16 (
    .Clk(clk), .Reset(rst_n), .InValid(iv16), .InReady(rdy16),
    .InputA(a_drv), .InputB(b_drv), .OP(op_drv), .SC_in(sc_drv),
    .imm(imm_drv), .Out(out16), .OutValid(ov16), .OutReady(out_ready),
    .Zero(z16), .Parity(p16), .OutBit(ob16), .Carry(c16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: compare on each result handshake.
  always @(negedge clk) begin
    if (rst_n && ov8 && out_ready) begin
      if (q8.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL w8 unexpected result: got 0x%0h, expected none", out8);
      end else begin
        e8 = q8.pop_front();
        check({e8.name, " out"},    32'(out8), 32'(e8.out[7:0]));
        check({e8.name, " carry"},  32'(c8),   32'(e8.c));
        check({e8.name, " zero"},   32'(z8),   32'(e8.z));
        check({e8.name, " parity"}, 32'(p8),   32'(e8.p));
        check({e8.name, " outbit"}, 32'(ob8),  32'(e8.b));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov16 && out_ready) begin
      if (q16.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL w16 unexpected result: got 0x%0h, expected none", out16);
      end else begin
        e16 = q16.pop_front();
        check({e16.name, " out"},    32'(out16), 32'(e16.out));
        check({e16.name, " carry"},  32'(c16),   32'(e16.c));
        check({e16.name, " zero"},   32'(z16),   32'(e16.z));
        check({e16.name, " parity"}, 32'(p16),   32'(e16.p));
        check({e16.name, " outbit"}, 32'(ob16),  32'(e16.b));
      end
    end
  end

  // Issue one op, push its expected result, then measure latency counting the
  // accept edge as edge 1. While busy, InReady must be low and Out unchanged.
  task automatic issue(input bit w16, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic sc, input logic [3:0] im,
                       input logic [15:0] eo, input logic ec, input logic ez,
                       input logic ep, input logic eb,
                       input int elat, input string name);
    exp_t        e;
    int          wait_n;
    int          lat;
    int          bad;
    logic [15:0] prev;
    e.out = eo; e.c = ec; e.z = ez; e.p = ep; e.b = eb; e.name = name;
    if (w16) q16.push_back(e);
    else     q8.push_back(e);
    wait_n = 0;
    @(negedge clk);
    while (!(w16 ? rdy16 : rdy8) && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check({name, " ready wait"}, 32'(wait_n < 50), 32'd1);
    prev   = w16 ? out16 : {8'h00, out8};
    op_drv = op; a_drv = a; b_drv = b; sc_drv = sc; imm_drv = im;
    if (w16) iv16 = 1'b1;
    else     iv8  = 1'b1;
    @(posedge clk);
    #1;
    iv8 = 1'b0; iv16 = 1'b0;
    a_drv   = 16'($urandom);
    b_drv   = 16'($urandom);
    sc_drv  = 1'($urandom);
    imm_drv = 4'($urandom);
    op_drv  = 4'($urandom);
    lat = 1;
    bad = 0;
    while (!(w16 ? ov16 : ov8) && lat < 64) begin
      if ((w16 ? rdy16 : rdy8) !== 1'b0) bad++;
      if ((w16 ? out16 : {8'h00, out8}) !== prev) bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    if ((w16 ? rdy16 : rdy8) !== 1'b0) bad++;
    check({name, " latency"},   32'(lat), 32'(elat));
    check({name, " busy hold"}, 32'(bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; iv8 = 1'b0; iv16 = 1'b0; out_ready = 1'b1;
    a_drv = '0; b_drv = '0; op_drv = '0; sc_drv = 1'b0; imm_drv = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out",      32'(out8), 32'h0);
    check("reset zero",     32'(z8),   32'd1);
    check("reset outvalid", 32'(ov8),  32'd0);
    check("reset carry",    32'(c8),   32'd0);
    check("reset parity",   32'(p8),   32'd0);
    check("reset outbit",   32'(ob8),  32'd0);
    rst_n = 1'b1;
    check("reset inready",  32'(rdy8), 32'd1);

    //     w16 op       A        B        sc    imm   out      c     z     p     b    lat name
    issue(0, OP_ADD,  16'hFF,  16'h01,  1'b0, 4'd0, 16'h00,  1'b1, 1'b1, 1'b0, 1'b0, 1, "add ff+01");
    issue(0, OP_MUL,  16'd13,  16'd11,  1'b0, 4'd0, 16'h8F,  1'b0, 1'b0, 1'b1, 1'b1, 9, "mul 13*11");
    issue(0, OP_MUL,  16'h20,  16'h10,  1'b0, 4'd0, 16'h00,  1'b1, 1'b1, 1'b0, 1'b0, 9, "mul 20*10");
    issue(0, OP_MUL,  16'hFF,  16'hFF,  1'b0, 4'd0, 16'h01,  1'b1, 1'b0, 1'b1, 1'b1, 9, "mul ff*ff");
    issue(0, OP_SHLN, 16'hB4,  16'h00,  1'b1, 4'd3, 16'hA7,  1'b1, 1'b0, 1'b1, 1'b1, 4, "shln b4 n3");
    issue(0, OP_SHLN, 16'hB4,  16'h00,  1'b1, 4'd0, 16'hB4,  1'b0, 1'b0, 1'b0, 1'b0, 1, "shln b4 n0");
    issue(0, OP_SHLN, 16'h80,  16'h00,  1'b0, 4'd7, 16'h00,  1'b0, 1'b1, 1'b0, 1'b0, 8, "shln 80 n7");
    issue(0, OP_LSH,  16'h81,  16'h00,  1'b0, 4'd0, 16'h02,  1'b1, 1'b0, 1'b1, 1'b0, 1, "lsh 81");
    issue(0, OP_XOR,  16'h07,  16'h00,  1'b0, 4'd0, 16'h01,  1'b0, 1'b0, 1'b1, 1'b1, 1, "xor 07");
    issue(0, OP_AND,  16'hF0,  16'h3C,  1'b0, 4'd0, 16'h30,  1'b0, 1'b0, 1'b0, 1'b0, 1, "and");
    issue(0, OP_BXOR, 16'hF0,  16'h3C,  1'b0, 4'd0, 16'hCC,  1'b0, 1'b0, 1'b0, 1'b0, 1, "bxor");
    issue(0, OP_FLIP, 16'h0F,  16'h00,  1'b0, 4'd7, 16'h8F,  1'b0, 1'b0, 1'b1, 1'b1, 1, "flip b7");
    issue(0, OP_SETB, 16'hFF,  16'h00,  1'b0, 4'd3, 16'hF7,  1'b0, 1'b0, 1'b1, 1'b1, 1, "setb b3=0");
    issue(0, OP_RSV,  16'h3C,  16'hFF,  1'b1, 4'd0, 16'h3C,  1'b0, 1'b0, 1'b0, 1'b0, 1, "reserved");

    // Back-pressure: result held, new request ignored, IDLE one edge after take.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(0, OP_GETB, 16'h04,  16'h00,  1'b0, 4'd2, 16'h04,  1'b0, 1'b0, 1'b1, 1'b1, 1, "getb hold");
    iv8 = 1'b1; op_drv = OP_ADD; a_drv = 16'h11; b_drv = 16'h22;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("hold out",      32'(out8), 32'h04);
      check("hold outbit",   32'(ob8),  32'd1);
      check("hold inready",  32'(rdy8), 32'd0);
      check("hold outvalid", 32'(ov8),  32'd1);
    end
    iv8 = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release outvalid", 32'(ov8),  32'd0);
    check("release inready",  32'(rdy8), 32'd1);

    // Reset in the middle of a MUL, then accept on the first edge after release.
    issue(0, OP_CPY,  16'h5A,  16'h00,  1'b0, 4'd0, 16'h5A,  1'b0, 1'b0, 1'b0, 1'b0, 1, "cpy 5a");
    @(negedge clk);
    while (!rdy8) @(negedge clk);
    op_drv = OP_MUL; a_drv = 16'd13; b_drv = 16'd11; iv8 = 1'b1;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort out",      32'(out8), 32'h0);
    check("abort outvalid", 32'(ov8),  32'd0);
    check("abort zero",     32'(z8),   32'd1);
    check("abort carry",    32'(c8),   32'd0);
    check("abort parity",   32'(p8),   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort inready",  32'(rdy8), 32'd1);
    issue(0, OP_ADD,  16'h01,  16'h01,  1'b0, 4'd0, 16'h02,  1'b0, 1'b0, 1'b1, 1'b0, 1, "add after reset");

    issue(1, OP_FLIP, 16'h0001, 16'h0, 1'b0, 4'd15, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b1, 1,  "w16 flip b15");
    issue(1, OP_SETB, 16'h00B4, 16'h0, 1'b1, 4'd1,  16'h00B6, 1'b0, 1'b0, 1'b1, 1'b0, 1,  "w16 setb b1");
    issue(1, OP_GETB, 16'h8000, 16'h0, 1'b0, 4'd15, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 1,  "w16 getb b15");
    issue(1, OP_MUL,  16'd300,  16'd200, 1'b0, 4'd0, 16'hEA60, 1'b0, 1'b0, 1'b1, 1'b0, 17, "w16 mul");

    repeat (4) @(posedge clk);
    #1;
    check("w8 scoreboard drained",  32'(q8.size()),  32'd0);
    check("w16 scoreboard drained", 32'(q16.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
